// File: rtl/projectile_pool_if.sv
// Projectile pool bus interface.
// Groups every non-clock signal of projectile_pool: frame tick source, fire request,
// shooter/target geometry, raster position, and the status outputs.
//   master : the fighter top level (drives requests and geometry, reads status)
//   slave  : projectile_pool itself
// NUM_SLOTS must match the NUM_SLOTS of the projectile_pool instance it connects to.
interface projectile_pool_if #(
  parameter int NUM_SLOTS = 4
);
  logic                 frame_clk;
  logic                 fire;
  logic                 fire_dir;
  logic [9:0]           Src_X;
  logic [9:0]           Src_Y;
  logic [9:0]           Target_X;
  logic [9:0]           Target_Y;
  logic [9:0]           Target_Size;
  logic [9:0]           DrawX;
  logic [9:0]           DrawY;
  logic                 is_proj;
  logic                 hit;
  logic [7:0]           hit_count;
  logic [NUM_SLOTS-1:0] active_mask;
  logic                 full;

  modport master (
    output frame_clk, fire, fire_dir, Src_X, Src_Y, Target_X, Target_Y, Target_Size,
           DrawX, DrawY,
    input  is_proj, hit, hit_count, active_mask, full
  );

  modport slave (
    input  frame_clk, fire, fire_dir, Src_X, Src_Y, Target_X, Target_Y, Target_Size,
           DrawX, DrawY,
    output is_proj, hit, hit_count, active_mask, full
  );
endinterface

// File: rtl/projectile_pool.sv
// Multi-slot projectile engine.
// Holds NUM_SLOTS projectiles launched from the shooter on a fire edge; all of them
// advance once per frame tick (rising edge of frame_clk seen in the Clk domain) and
// retire on target contact or screen-edge exit.
// Ports:
//   Clk   : system clock
//   Reset : asynchronous, active-high, clears all state
//   bus   : projectile_pool_if.slave
//     in  frame_clk, fire, fire_dir, Src_X/Y, Target_X/Y, Target_Size, DrawX/Y
//     out is_proj (combinational), hit (1-Clk pulse), hit_count (saturating),
//         active_mask, full
// Optional feature: define PROJ_POOL_GRAVITY_EN to give each slot a vertical
// velocity (launched at -6, +1 per tick, saturating at +15) and retire at Y >= 479.
module projectile_pool #(
  parameter int NUM_SLOTS = 4,
  parameter int STEP      = 2,
  parameter int PROJ_R    = 3,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int COOLDOWN  = 8
) (
  input logic              Clk,
  input logic              Reset,
  projectile_pool_if.slave bus
);

  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic [11:0]        RADIUS = 12'(PROJ_R);
  localparam logic [9:0]         XMIN_V = 10'(X_MIN);
  localparam logic [9:0]         XMAX_V = 10'(X_MAX);
  // The launch tick also counts as the first cooldown decrement, so launches are
  // exactly COOLDOWN ticks apart.
  localparam logic [7:0]         CD_RELOAD = 8'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  function automatic logic [11:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [11:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic left);
    logic signed [11:0] s;
    s = left ? $signed({2'b00, x}) - STEP_S : $signed({2'b00, x}) + STEP_S;
    if (s < 0) return '0;
    if (s > 12'sd1023) return '1;
    return s[9:0];
  endfunction

`ifdef PROJ_POOL_GRAVITY_EN
  function automatic logic [9:0] step_y(input logic [9:0] y, input logic signed [5:0] vy);
    logic signed [11:0] s;
    s = $signed({2'b00, y}) + $signed({{6{vy[5]}}, vy});
    if (s < 0) return '0;
    if (s > 12'sd1023) return '1;
    return s[9:0];
  endfunction
`endif

  logic                 frame_prev, fire_prev, pending;
  logic [7:0]           cooldown;
  logic [NUM_SLOTS-1:0] active, dir;
  logic [9:0]           pos_x [NUM_SLOTS];
  logic [9:0]           pos_y [NUM_SLOTS];
`ifdef PROJ_POOL_GRAVITY_EN
  logic signed [5:0]    vel_y   [NUM_SLOTS];
  logic signed [5:0]    next_vy [NUM_SLOTS];
`endif
  logic                 hit_q;
  logic [7:0]           hit_count_q;

  logic [9:0]           next_x [NUM_SLOTS];
  logic [9:0]           next_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] contact, retire, launch_sel;
  logic [3:0]           n_contact;
  logic [8:0]           count_sum;
  logic [11:0]          reach;
  logic                 tick, fire_edge, any_free, launch, draw_hit;

  assign tick      = bus.frame_clk & ~frame_prev;
  assign fire_edge = bus.fire & ~fire_prev;
  assign reach     = {2'b00, bus.Target_Size} + RADIUS;
  assign count_sum = {1'b0, hit_count_q} + {5'b0, n_contact};

  // Candidate post-tick position, contact and retirement per slot.
  always_comb begin
    n_contact = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      next_x[i] = step_x(pos_x[i], dir[i]);
`ifdef PROJ_POOL_GRAVITY_EN
      next_y[i]  = step_y(pos_y[i], vel_y[i]);
      next_vy[i] = (vel_y[i] == 6'sd15) ? vel_y[i] : vel_y[i] + 6'sd1;
`else
      next_y[i]  = pos_y[i];
`endif
      contact[i] = active[i] && (abs_diff(next_x[i], bus.Target_X) <= reach)
                             && (abs_diff(next_y[i], bus.Target_Y) <= reach);
      retire[i]  = contact[i] || (next_x[i] <= XMIN_V) || (next_x[i] >= XMAX_V);
`ifdef PROJ_POOL_GRAVITY_EN
      if (next_y[i] >= 10'd479) retire[i] = 1'b1;
`endif
      n_contact = n_contact + 4'(contact[i]);
    end
  end

  // Lowest-index slot free before the tick; slots retiring on this tick are not candidates.
  always_comb begin
    launch_sel = '0;
    any_free   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!active[i] && !any_free) begin
        launch_sel[i] = 1'b1;
        any_free      = 1'b1;
      end
    end
  end

  assign launch = tick && pending && (cooldown == '0) && any_free;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_prev  <= 1'b0;
      fire_prev   <= 1'b0;
      pending     <= 1'b0;
      cooldown    <= '0;
      active      <= '0;
      dir         <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
`ifdef PROJ_POOL_GRAVITY_EN
        vel_y[i] <= '0;
`endif
      end
    end else begin
      frame_prev <= bus.frame_clk;
      fire_prev  <= bus.fire;
      hit_q      <= 1'b0;
      if (tick) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (launch && launch_sel[i]) begin
            active[i] <= 1'b1;
            dir[i]    <= bus.fire_dir;
            pos_x[i]  <= bus.Src_X;
            pos_y[i]  <= bus.Src_Y;
`ifdef PROJ_POOL_GRAVITY_EN
            vel_y[i]  <= -6'sd6;
`endif
          end else if (active[i]) begin
            pos_x[i] <= next_x[i];
            pos_y[i] <= next_y[i];
`ifdef PROJ_POOL_GRAVITY_EN
            vel_y[i] <= next_vy[i];
`endif
            if (retire[i]) active[i] <= 1'b0;
          end
        end
        if (launch) begin
          pending  <= 1'b0;
          cooldown <= CD_RELOAD;
        end else if (cooldown != '0) begin
          cooldown <= cooldown - 8'd1;
        end
        hit_q       <= |contact;
        hit_count_q <= count_sum[8] ? 8'hFF : count_sum[7:0];
      end
      // Placed last so a fire edge coinciding with a launch stays pending.
      if (fire_edge) pending <= 1'b1;
    end
  end

  always_comb begin
    draw_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (active[i] && (abs_diff(bus.DrawX, pos_x[i]) <= RADIUS)
                    && (abs_diff(bus.DrawY, pos_y[i]) <= RADIUS))
        draw_hit = 1'b1;
    end
  end

  assign bus.is_proj     = draw_hit;
  assign bus.hit         = hit_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.active_mask = active;
  assign bus.full        = &active;

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool (default build, PROJ_POOL_GRAVITY_EN undefined).
// A slot-list reference model is stepped on every frame tick the bench generates.
module tb_projectile_pool;
  localparam int NS   = 4;
  localparam int STP  = 2;
  localparam int R    = 3;
  localparam int XMIN = 0;
  localparam int XMAX = 639;
  localparam int CD   = 8;

  logic Clk = 1'b0;
  logic Reset;

  projectile_pool_if #(.NUM_SLOTS(NS)) bus ();

  projectile_pool #(
    .NUM_SLOTS(NS), .STEP(STP), .PROJ_R(R), .X_MIN(XMIN), .X_MAX(XMAX), .COOLDOWN(CD)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  int mx [NS];
  int my [NS];
  bit ma [NS];
  bit md [NS];
  bit mpend;
  int mcool, mhc, mnhit;
  logic obs_hit;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [NS-1:0] model_mask();
    logic [NS-1:0] m;
    for (int i = 0; i < NS; i++) m[i] = ma[i];
    return m;
  endfunction

  function automatic bit model_isproj(input int px, input int py);
    bit r = 0;
    for (int i = 0; i < NS; i++)
      if (ma[i] && iabs(px - mx[i]) <= R && iabs(py - my[i]) <= R) r = 1;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      ma[i] = 0; mx[i] = 0; my[i] = 0; md[i] = 0;
    end
    mpend = 0; mcool = 0; mhc = 0; mnhit = 0;
  endtask

  task automatic model_tick();
    bit was_free [NS];
    bit done;
    int reach;
    reach = int'(bus.Target_Size) + R;
    mnhit = 0;
    for (int i = 0; i < NS; i++) was_free[i] = !ma[i];
    for (int i = 0; i < NS; i++) begin
      if (ma[i]) begin
        mx[i] = md[i] ? mx[i] - STP : mx[i] + STP;
        if (mx[i] < 0) mx[i] = 0;
        if (mx[i] > 1023) mx[i] = 1023;
        if (iabs(mx[i] - int'(bus.Target_X)) <= reach &&
            iabs(my[i] - int'(bus.Target_Y)) <= reach) begin
          mnhit++;
          ma[i] = 0;
        end else if (mx[i] <= XMIN || mx[i] >= XMAX) begin
          ma[i] = 0;
        end
      end
    end
    done = 0;
    if (mpend && mcool == 0) begin
      for (int i = 0; i < NS; i++) begin
        if (was_free[i] && !done) begin
          ma[i] = 1; mx[i] = int'(bus.Src_X); my[i] = int'(bus.Src_Y); md[i] = bus.fire_dir;
          mpend = 0; mcool = CD; done = 1;
        end
      end
    end
    if (mcool > 0) mcool--;
    mhc = (mhc + mnhit > 255) ? 255 : mhc + mnhit;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input bit exp_hit);
    chk({tag, ".mask"}, 32'(bus.active_mask), 32'(model_mask()));
    chk({tag, ".full"}, 32'(bus.full), 32'(&model_mask()));
    chk({tag, ".hit"}, 32'(bus.hit), 32'(exp_hit));
    chk({tag, ".hit_count"}, 32'(bus.hit_count), 32'(mhc));
  endtask

  task automatic probe(input string tag);
    int px, py, k;
    k = int'($urandom_range(0, NS - 1));
    if (ma[k]) begin
      px = mx[k] + int'($urandom_range(0, 9)) - 4;
      py = my[k] + int'($urandom_range(0, 9)) - 4;
    end else begin
      px = int'($urandom_range(0, 1023));
      py = int'($urandom_range(0, 1023));
    end
    if (px < 0) px = 0;
    if (px > 1023) px = 1023;
    if (py < 0) py = 0;
    if (py > 1023) py = 1023;
    bus.DrawX = 10'(px);
    bus.DrawY = 10'(py);
    #1;
    chk({tag, ".is_proj"}, 32'(bus.is_proj), 32'(model_isproj(px, py)));
  endtask

  task automatic do_tick(input string tag);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    @(posedge Clk);
    model_tick();
    #1;
    obs_hit = bus.hit;
    check_state(tag, mnhit > 0);
    probe(tag);
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, ".hit_width"}, 32'(bus.hit), 32'd0);
  endtask

  task automatic do_fire(input logic d);
    @(negedge Clk);
    bus.fire     = 1'b1;
    bus.fire_dir = d;
    @(posedge Clk);
    mpend = 1;
    @(negedge Clk);
    bus.fire = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.fire = 1'b0;
    model_clear();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.frame_clk = 1'b0; bus.fire = 1'b0; bus.fire_dir = 1'b0;
    bus.Src_X = '0; bus.Src_Y = '0;
    bus.Target_X = '0; bus.Target_Y = '0; bus.Target_Size = '0;
    bus.DrawX = '0; bus.DrawY = '0;
    model_clear();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_state("reset", 0);
    chk("reset.is_proj", 32'(bus.is_proj), 32'd0);

    // Single projectile flying into the target
    bus.Src_X = 10'd280; bus.Src_Y = 10'd375;
    bus.Target_X = 10'd360; bus.Target_Y = 10'd375; bus.Target_Size = 10'd20;
    do_fire(1'b0);
    for (int t = 1; t <= 30; t++) begin
      do_tick("flight");
      if (t == 1) begin
        bus.DrawX = 10'd283; bus.DrawY = 10'd375; #1;
        chk("draw.edge_in", 32'(bus.is_proj), 32'd1);
        bus.DrawX = 10'd284; #1;
        chk("draw.edge_out", 32'(bus.is_proj), 32'd0);
      end
      if (t == 29) chk("flight.no_hit_29", 32'(obs_hit), 32'd0);
      if (t == 30) begin
        chk("flight.hit_30", 32'(obs_hit), 32'd1);
        chk("flight.count_30", 32'(bus.hit_count), 32'd1);
      end
    end

    // Reset while three slots are in flight
    bus.Src_X = 10'd100; bus.Target_Y = 10'd100;
    repeat (3) begin
      do_fire(1'b0);
      repeat (10) do_tick("midrst.setup");
    end
    chk("midrst.pre_mask", 32'(bus.active_mask), 32'h7);
    bus.DrawX = 10'(mx[0]); bus.DrawY = 10'(my[0]);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst.mask", 32'(bus.active_mask), 32'd0);
    chk("midrst.is_proj", 32'(bus.is_proj), 32'd0);
    chk("midrst.hit_count", 32'(bus.hit_count), 32'd0);
    chk("midrst.full", 32'(bus.full), 32'd0);
    model_clear();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) do_tick("midrst.after");

    // Pool full: fifth launch waits for slot 0 to leave at X_MAX
    apply_reset();
    bus.Src_X = 10'd280; bus.Src_Y = 10'd375; bus.Target_Y = 10'd100;
    begin
      int t;
      t = 0;
      for (int f = 0; f < 5; f++) begin
        do_fire(1'b0);
        repeat (10) begin
          do_tick("full");
          t++;
          if (t == 40) chk("full.flag_40", 32'(bus.full), 32'd1);
        end
      end
      while (t < 185) begin
        do_tick("full");
        t++;
        if (t == 181) chk("full.slot0_retired", 32'(bus.active_mask[0]), 32'd0);
        if (t == 182) chk("full.slot0_relaunch", 32'(bus.active_mask[0]), 32'd1);
      end
    end

    // Cooldown: fire edges two ticks apart launch eight ticks apart
    apply_reset();
    do_fire(1'b0);
    do_tick("cool");
    do_tick("cool");
    do_fire(1'b0);
    for (int t = 3; t <= 12; t++) begin
      do_tick("cool");
      if (t == 8) chk("cool.mask_8", 32'(bus.active_mask), 32'h1);
      if (t == 9) chk("cool.mask_9", 32'(bus.active_mask), 32'h3);
    end

    // Randomized traffic
    apply_reset();
    bus.Target_X = 10'd320; bus.Target_Y = 10'd380; bus.Target_Size = 10'd15;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.Src_X = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                : 10'($urandom_range(40, 600));
        bus.Src_Y = 10'($urandom_range(340, 420));
        do_fire(1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 39) == 0) begin
        bus.Target_X    = 10'($urandom_range(0, 639));
        bus.Target_Y    = 10'($urandom_range(340, 420));
        bus.Target_Size = 10'($urandom_range(0, 40));
      end
      do_tick("rand");
    end

    // Saturation: 252 single hits, then two double hits
    apply_reset();
    bus.Target_X = 10'd500; bus.Target_Y = 10'd200; bus.Target_Size = 10'd20;
    bus.Src_X = 10'd500; bus.Src_Y = 10'd200;
    repeat (252) begin
      do_fire(1'b0);
      repeat (8) do_tick("sat.single");
    end
    chk("sat.count_252", 32'(bus.hit_count), 32'd252);
    for (int r = 0; r < 2; r++) begin
      bus.Src_X = 10'd400;
      do_fire(1'b0);
      repeat (8) do_tick("sat.double");
      bus.Src_X = 10'd416;
      do_fire(1'b0);
      repeat (45) do_tick("sat.double");
      chk((r == 0) ? "sat.count_254" : "sat.count_255", 32'(bus.hit_count),
          (r == 0) ? 32'd254 : 32'd255);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
